key_conditioner: RTL and testbench

Front-end conditioner for the clock board's active-low pushbuttons (hour/minute/second adjust keys). Each raw key is synchronised to `clk`, debounced, and converted into single-cycle press pulses, with optional auto-repeat while held. Its outputs drive the time-of-day/alarm adjust logic, which then steps one unit per pulse instead of sampling raw key levels on the 1 Hz tick.

---
 rtl/key_conditioner.sv | 146 ++++++++++++++
 tb/tb_key_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner
//  Purpose  : Conditions active-low pushbuttons into debounced levels and
//             single-cycle press pulses, with optional per-key auto-repeat.
//             Every key channel is independent. Bit i of each vector is key i.
//  Ports    : clk            - system clock
//             rst_n          - synchronous active-low reset
//             i_key_n        - raw asynchronous keys (0 = pressed)
//             i_repeat_en    - per-key auto-repeat enable
//             o_key_level    - debounced level (1 = pressed)
//             o_press_pulse  - one-cycle pulse per press and per repeat
//  Revision : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    input  logic [N_KEYS-1:0] i_repeat_en,
    output logic [N_KEYS-1:0] o_key_level,
    output logic [N_KEYS-1:0] o_press_pulse
);

    localparam int c_DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RCNT_W = $clog2(c_RMAX);

    localparam logic [c_DCNT_W-1:0] c_DCNT_TC   = c_DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RCNT_W-1:0] c_DELAY_TC  = c_RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RCNT_W-1:0] c_PERIOD_TC = c_RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [1:0]          r_sync;
        logic [c_DCNT_W-1:0] r_dcnt;
        logic                r_level;      // stable level, 1 = pressed
        logic                r_pulse;
        logic [c_RCNT_W-1:0] r_rcnt;
        state_t              r_state;

        logic                w_differ;
        logic                w_accept;
        logic                w_level_nxt;
        state_t              w_state_nxt;
        logic [c_RCNT_W-1:0] w_rcnt_nxt;
        logic                w_pulse_nxt;

        assign w_differ    = (~r_sync[1]) != r_level;
        assign w_accept    = w_differ && (r_dcnt == c_DCNT_TC);
        // The FSM looks at the level being registered this edge so that the
        // press pulse coincides with key_level rising, and so that a release
        // accepted on a repeat terminal count wins over the repeat.
        assign w_level_nxt = w_accept ? ~r_level : r_level;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync  <= 2'b11;
                r_dcnt  <= '0;
                r_level <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], i_key_n[i]};
                r_level <= w_level_nxt;
                if (!w_differ || w_accept) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_pulse_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_level_nxt && !r_level) begin
                        w_pulse_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (!w_level_nxt) begin
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else if (!i_repeat_en[i]) begin
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt == c_DELAY_TC) begin
                        w_pulse_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!w_level_nxt) begin
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else if (!i_repeat_en[i]) begin
                        // Disabling repeat restarts the full initial delay.
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_DELAY;
                    end else if (r_rcnt == c_PERIOD_TC) begin
                        w_pulse_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 1'b1;
                    end
                end
                default: begin
                    w_rcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        assign o_key_level[i]   = r_level;
        assign o_press_pulse[i] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_key_conditioner
//  Purpose  : Self-checking bench for key_conditioner with small parameters
//             (debounce 4, repeat delay 10, repeat period 3). Step k drives
//             inputs sampled at edge k and checks outputs just after edge k.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [NK-1:0] key_n  = '1;
    logic [NK-1:0] rep_en = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_key_n       (key_n),
        .i_repeat_en   (rep_en),
        .o_key_level   (key_level),
        .o_press_pulse (press_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst_n;
        logic [NK-1:0] key_n;
        logic [NK-1:0] rep_en;
        logic [NK-1:0] exp_level;
        logic [NK-1:0] exp_pulse;
        int            test_id;
        int            step;
    } vec_t;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] pulse;
        int            test_id;
        int            step;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic string tname(input int id);
        case (id)
            1:       return "reset";
            2:       return "clean_press";
            3:       return "bounce";
            4:       return "auto_repeat";
            5:       return "repeat_disabled";
            6:       return "release_on_repeat";
            7:       return "reset_mid_repeat";
            8:       return "concurrent";
            default: return "unknown";
        endcase
    endfunction

    function automatic void add(input logic rs, input logic [NK-1:0] kn,
                                input logic [NK-1:0] en, input logic [NK-1:0] lv,
                                input logic [NK-1:0] pl, input int id, input int st);
        vec_t v;
        v.rst_n = rs; v.key_n = kn; v.rep_en = en;
        v.exp_level = lv; v.exp_pulse = pl; v.test_id = id; v.step = st;
        tbl.push_back(v);
    endfunction

    function automatic void add_reset(input int id, input int n);
        for (int j = 0; j < n; j++) add(1'b0, 3'b111, 3'b111, 3'b000, 3'b000, id, -1);
    endfunction

    initial begin
        logic [NK-1:0] kn, lv, pl, en;
        logic          rs;
        int            st;
        vec_t          v;
        exp_t          e;

        // 1: reset held with keys idle, then nothing ever appears
        add_reset(1, 3);
        for (int k = 0; k < 20; k++) add(1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 1, k);

        // 2: clean press on key 0, released at step 11. Accepted at step 5;
        //    the first repeat (offset 10, step 15) precedes release
        //    acceptance at step 16, which itself produces no pulse.
        add_reset(2, 3);
        for (int k = 0; k < 25; k++) begin
            kn = 3'b111; kn[0] = (k < 11) ? 1'b0 : 1'b1;
            lv = 3'b000; lv[0] = (k >= 5 && k < 16);
            pl = 3'b000; pl[0] = (k == 5 || k == 15);
            add(1'b1, kn, 3'b111, lv, pl, 2, k);
        end

        // 3: key 1 bounces 3 low / 1 high five times, then stays high
        add_reset(3, 3);
        st = 0;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                kn = 3'b111; kn[1] = (j < 3) ? 1'b0 : 1'b1;
                add(1'b1, kn, 3'b111, 3'b000, 3'b000, 3, st);
                st++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            add(1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 3, st);
            st++;
        end

        // 4: key 2 held; pulses at steps 5 + {0,10,13,16,...,28}
        add_reset(4, 3);
        for (int k = 0; k < 36; k++) begin
            lv = 3'b000; lv[2] = (k >= 5);
            pl = 3'b000; pl[2] = (k == 5) || (k >= 15 && ((k - 15) % 3) == 0);
            add(1'b1, 3'b011, 3'b111, lv, pl, 4, k);
        end

        // 5: same hold with repeat disabled on key 2: only the press pulse
        add_reset(5, 3);
        for (int k = 0; k < 36; k++) begin
            lv = 3'b000; lv[2] = (k >= 5);
            pl = 3'b000; pl[2] = (k == 5);
            add(1'b1, 3'b011, 3'b011, lv, pl, 5, k);
        end

        // 6: release of key 2 accepted at step 21, where a repeat would fire
        add_reset(6, 3);
        for (int k = 0; k < 29; k++) begin
            kn = 3'b111; kn[2] = (k < 16) ? 1'b0 : 1'b1;
            lv = 3'b000; lv[2] = (k >= 5 && k < 21);
            pl = 3'b000; pl[2] = (k == 5 || k == 15 || k == 18);
            add(1'b1, kn, 3'b111, lv, pl, 6, k);
        end

        // 7: one-cycle reset at step 20 during REPEAT, key still held;
        //    fresh press pulse 6 edges later at step 26
        add_reset(7, 3);
        for (int k = 0; k < 31; k++) begin
            rs = (k == 20) ? 1'b0 : 1'b1;
            lv = 3'b000; lv[2] = (k >= 5 && k < 20) || (k >= 26);
            pl = 3'b000; pl[2] = (k == 5 || k == 15 || k == 18 || k == 26);
            add(rs, 3'b011, 3'b111, lv, pl, 7, k);
        end

        // 8: all three keys pressed on the same edge
        add_reset(8, 3);
        for (int k = 0; k < 13; k++) begin
            lv = (k >= 5) ? 3'b111 : 3'b000;
            pl = (k == 5) ? 3'b111 : 3'b000;
            add(1'b1, 3'b000, 3'b111, lv, pl, 8, k);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            v      = tbl[i];
            rst_n  = v.rst_n;
            key_n  = v.key_n;
            rep_en = v.rep_en;
            e.level = v.exp_level; e.pulse = v.exp_pulse;
            e.test_id = v.test_id; e.step = v.step;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (key_level !== e.level) begin
                n_err++;
                $display("FAIL %s level step %0d: got %b, expected %b",
                         tname(e.test_id), e.step, key_level, e.level);
            end
            n_cmp++;
            if (press_pulse !== e.pulse) begin
                n_err++;
                $display("FAIL %s pulse step %0d: got %b, expected %b",
                         tname(e.test_id), e.step, press_pulse, e.pulse);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
